// File: rtl/instr_fmt_pkg.sv
// Instruction-format package: field bit positions, request kinds, encoder
// FSM states and the chunk widths used when expanding a 32-bit LI.
package instr_fmt_pkg;

  // Field positions inside the 32-bit word
  localparam int OP_LSB    = 29;
  localparam int PRED_BIT  = 28;
  localparam int RD_LSB    = 23;
  localparam int RS1_LSB   = 18;
  localparam int IMMHI_LSB = 14;  // imm[13:10]
  localparam int FUNCT_LSB = 10;  // funct4
  localparam int IMMLO_LSB = 0;   // imm[9:0]
  localparam int RS2_LSB   = 0;

  localparam int IMM14_W   = 14;

  // LI expansion: top 10 bits sign-extended, then two 11-bit chunks
  localparam int LI_TOP_W     = 10;
  localparam int LI_CHUNK_W   = 11;
  localparam int LI_SHAMT     = 11;
  localparam logic [2:0] LI_LAST_STEP = 3'd4;

  typedef enum logic [1:0] {
    KIND_RAW  = 2'b00,
    KIND_LI   = 2'b01,
    KIND_NOP  = 2'b10,
    KIND_EXIT = 2'b11
  } req_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXPAND = 2'b01,
    ST_HALT   = 2'b10
  } state_e;

  // True when v is representable as a signed 14-bit immediate
  function automatic logic fits_imm14(input logic [31:0] v);
    return (v[31:13] == 19'h00000) || (v[31:13] == 19'h7FFFF);
  endfunction

endpackage

// File: rtl/define.sv
// Shared opcode and function-code macros for the instruction formats.
// Included by every file that needs the encoding constants. The include
// guard lets several files include it in one compilation.
`ifndef INSTR_DEFINE_SV
`define INSTR_DEFINE_SV

// 3-bit major opcodes
`define Rtype   3'b000
`define Itype   3'b001
`define Mtype   3'b010
`define Ctype   3'b011
`define Ptype   3'b100
`define Ftype   3'b101

// 4-bit ALU function codes
`define ALU_ADD 4'b0000
`define ALU_SUB 4'b0001
`define ALU_SLL 4'b0010
`define ALU_SRL 4'b0011
`define ALU_AND 4'b0100
`define ALU_OR  4'b0101
`define ALU_XOR 4'b0110

// Control-type function that stops the core
`define C_EXIT  3'b111

`endif

// File: rtl/instr_pack.sv
// Combinational field packer.
//   op/pred/funct4/rd/rs1/rs2/imm14 in -> 32-bit instruction word out.
// R/F carry funct4 and rs2 ([9:5] zero, no immediate). I/M/C/P use the
// split immediate {[17:14],[9:0]}; I/M also carry funct4 (I needs it to tell
// ADDI from SLLI), C carries a 3-bit funct3 in [12:10], P has no function.
`include "define.sv"

module instr_pack
  import instr_fmt_pkg::*;
(
  input  logic [2:0]  op,
  input  logic        pred,
  input  logic [3:0]  funct4,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [13:0] imm14,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    word[OP_LSB +: 3]   = op;
    word[PRED_BIT]      = pred;
    word[RD_LSB +: 5]   = rd;
    word[RS1_LSB +: 5]  = rs1;
    case (op)
      `Rtype, `Ftype: begin
        word[FUNCT_LSB +: 4] = funct4;
        word[RS2_LSB +: 5]   = rs2;
      end
      `Ctype: begin
        word[FUNCT_LSB +: 4]  = {1'b0, funct4[2:0]};
        word[IMMHI_LSB +: 4]  = imm14[13:10];
        word[IMMLO_LSB +: 10] = imm14[9:0];
      end
      `Itype, `Mtype: begin
        word[FUNCT_LSB +: 4]  = funct4;
        word[IMMHI_LSB +: 4]  = imm14[13:10];
        word[IMMLO_LSB +: 10] = imm14[9:0];
      end
      default: begin
        word[IMMHI_LSB +: 4]  = imm14[13:10];
        word[IMMLO_LSB +: 10] = imm14[9:0];
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts loader requests (RAW, LI, NOP, EXIT), expands
// pseudo-ops into legal words and streams them out one per handshake with an
// auto-incrementing word address.
//   req_*        request handshake and fields
//   instr_*      output word stream (registered, held under backpressure)
//   overflow     sticky, set when the address wraps
//   halted       set once the EXIT word has been accepted
// Only DATA_WIDTH = 32 is supported.
`include "define.sv"

module instr_encoder
  import instr_fmt_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_kind,
  input  logic [2:0]            req_op,
  input  logic                  req_pred,
  input  logic [3:0]            req_funct4,
  input  logic [4:0]            req_rd,
  input  logic [4:0]            req_rs1,
  input  logic [4:0]            req_rs2,
  input  logic [31:0]           req_imm,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  overflow,
  output logic                  halted
);

  state_e                state_reg, state_next;
  logic [2:0]            step_reg;        // index of word currently presented
  logic [2*LI_CHUNK_W-1:0] li_imm_reg;    // low 22 bits of the LI immediate
  logic [4:0]            li_rd_reg;
  logic                  exit_pend_reg;   // EXIT word presented, not yet taken
  logic                  instr_valid_reg;
  logic [DATA_WIDTH-1:0] instr_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  overflow_reg;
  logic                  halted_reg;

  logic                  req_fire, word_fire, expand_start;
  logic [2:0]            step_next;
  logic [2:0]            p_op;
  logic                  p_pred;
  logic [3:0]            p_funct4;
  logic [4:0]            p_rd, p_rs1, p_rs2;
  logic [13:0]           p_imm;
  logic [31:0]           pack_word;

  assign req_ready = !rst && (state_reg == ST_IDLE) && !exit_pend_reg &&
                     (!instr_valid_reg || instr_ready);
  assign req_fire  = req_valid && req_ready;
  assign word_fire = instr_valid_reg && instr_ready;
  assign step_next = step_reg + 3'd1;

  // Field selection for the next word to load into the output register
  always_comb begin
    p_op         = `Itype;
    p_pred       = 1'b0;
    p_funct4     = `ALU_ADD;
    p_rd         = '0;
    p_rs1        = '0;
    p_rs2        = '0;
    p_imm        = '0;
    expand_start = 1'b0;
    if (state_reg == ST_EXPAND) begin
      p_rd  = li_rd_reg;
      p_rs1 = li_rd_reg;
      case (step_next)
        3'd1, 3'd3: begin
          p_funct4 = `ALU_SLL;
          p_imm    = 14'(LI_SHAMT);
        end
        3'd2:    p_imm = {3'b000, li_imm_reg[2*LI_CHUNK_W-1:LI_CHUNK_W]};
        default: p_imm = {3'b000, li_imm_reg[LI_CHUNK_W-1:0]};
      endcase
    end else begin
      case (req_kind_e'(req_kind))
        KIND_RAW: begin
          p_op     = req_op;
          p_pred   = req_pred;
          p_funct4 = req_funct4;
          p_rd     = req_rd;
          p_rs1    = req_rs1;
          p_rs2    = req_rs2;
          p_imm    = req_imm[IMM14_W-1:0];
        end
        KIND_LI: begin
          // rd = x0 collapses to a plain NOP whatever the immediate
          if (req_rd != 5'd0) begin
            p_rd = req_rd;
            if (fits_imm14(req_imm)) begin
              p_imm = req_imm[IMM14_W-1:0];
            end else begin
              p_imm        = {{(IMM14_W-LI_TOP_W){req_imm[31]}}, req_imm[31:32-LI_TOP_W]};
              expand_start = 1'b1;
            end
          end
        end
        KIND_EXIT: begin
          p_op     = `Ctype;
          p_funct4 = {1'b0, `C_EXIT};
        end
        default: ;  // NOP: ADDI x0,x0,0 from the defaults
      endcase
    end
  end

  instr_pack u_pack (
    .op     (p_op),
    .pred   (p_pred),
    .funct4 (p_funct4),
    .rd     (p_rd),
    .rs1    (p_rs1),
    .rs2    (p_rs2),
    .imm14  (p_imm),
    .word   (pack_word)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_fire && expand_start)
          state_next = ST_EXPAND;
        else if (!req_fire && word_fire && exit_pend_reg)
          state_next = ST_HALT;
      end
      ST_EXPAND: begin
        if (word_fire && step_reg == LI_LAST_STEP)
          state_next = ST_IDLE;
      end
      default: state_next = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      step_reg        <= '0;
      li_imm_reg      <= '0;
      li_rd_reg       <= '0;
      exit_pend_reg   <= 1'b0;
      instr_valid_reg <= 1'b0;
      instr_reg       <= '0;
      addr_reg        <= '0;
      overflow_reg    <= 1'b0;
      halted_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (word_fire) begin
        addr_reg <= addr_reg + 1'b1;
        if (addr_reg == '1)
          overflow_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (req_fire) begin
            instr_reg       <= DATA_WIDTH'(pack_word);
            instr_valid_reg <= 1'b1;
            if (expand_start) begin
              step_reg   <= '0;
              li_imm_reg <= req_imm[2*LI_CHUNK_W-1:0];
              li_rd_reg  <= req_rd;
            end
            if (req_kind_e'(req_kind) == KIND_EXIT)
              exit_pend_reg <= 1'b1;
          end else if (word_fire) begin
            instr_valid_reg <= 1'b0;
            if (exit_pend_reg) begin
              exit_pend_reg <= 1'b0;
              halted_reg    <= 1'b1;
            end
          end
        end
        ST_EXPAND: begin
          if (word_fire) begin
            if (step_reg == LI_LAST_STEP) begin
              instr_valid_reg <= 1'b0;
            end else begin
              step_reg  <= step_next;
              instr_reg <= DATA_WIDTH'(pack_word);
            end
          end
        end
        default: instr_valid_reg <= 1'b0;
      endcase
    end
  end

  assign instr_valid = instr_valid_reg;
  assign instr       = instr_reg;
  assign instr_addr  = addr_reg;
  assign overflow    = overflow_reg;
  assign halted      = halted_reg;

endmodule

// File: tb/tb_instr_encoder.sv
`include "define.sv"

module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_kind;
  logic [2:0]  req_op;
  logic        req_pred;
  logic [3:0]  req_funct4;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        instr_valid, instr_ready;
  logic [31:0] instr;
  logic [9:0]  instr_addr;
  logic        overflow, halted;

  // Second instance with a 2-bit address to exercise wrap-around
  logic        s_rst, s_req_valid, s_req_ready, s_instr_valid;
  logic [1:0]  s_req_kind;
  logic [4:0]  s_req_rd;
  logic [31:0] s_instr;
  logic [1:0]  s_instr_addr;
  logic        s_overflow, s_halted;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_op(req_op), .req_pred(req_pred),
    .req_funct4(req_funct4), .req_rd(req_rd), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_imm(req_imm), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_addr(instr_addr),
    .overflow(overflow), .halted(halted)
  );

  instr_encoder #(.ADDR_WIDTH(2)) u_small (
    .clk(clk), .rst(s_rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_kind(s_req_kind), .req_op(`Rtype), .req_pred(1'b0),
    .req_funct4(`ALU_ADD), .req_rd(s_req_rd), .req_rs1(5'd0),
    .req_rs2(5'd0), .req_imm(32'd0), .instr_valid(s_instr_valid),
    .instr_ready(1'b1), .instr(s_instr), .instr_addr(s_instr_addr),
    .overflow(s_overflow), .halted(s_halted)
  );

  typedef struct {
    string       name;
    logic [1:0]  kind;
    logic [2:0]  op;
    logic        pred;
    logic [3:0]  f4;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    int          n;
    logic [4:0][31:0] w;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   addr_model = 0;
  vec_t vecs[14];

  function automatic vec_t mk(string nm, logic [1:0] k, logic [2:0] op, logic p,
                              logic [3:0] f4, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic [31:0] imm, int n,
                              logic [31:0] w0, logic [31:0] w1, logic [31:0] w2,
                              logic [31:0] w3, logic [31:0] w4);
    vec_t v;
    v.name = nm; v.kind = k; v.op = op; v.pred = p; v.f4 = f4;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.n = n;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present a request at a negedge and hold it until accepted (bounded)
  task automatic send(input vec_t v);
    int t = 0;
    req_kind = v.kind; req_op = v.op; req_pred = v.pred; req_funct4 = v.f4;
    req_rd = v.rd; req_rs1 = v.rs1; req_rs2 = v.rs2; req_imm = v.imm;
    req_valid = 1'b1;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) begin
      errors++;
      $display("FAIL %s accept timeout: req_ready stuck at 0", v.name);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    send(v);
    for (int i = 0; i < v.n; i++) begin
      chk($sformatf("%s valid[%0d]", v.name, i), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("%s word[%0d]", v.name, i), instr, v.w[i]);
      chk($sformatf("%s addr[%0d]", v.name, i), {22'd0, instr_addr}, 32'(addr_model));
      $display("txn %s word %0d: instr=%h addr=%0d", v.name, i, instr, instr_addr);
      addr_model++;
      @(negedge clk);
    end
    chk({v.name, " idle after"}, {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    vec_t big, raw1, ex;
    rst = 1'b1; s_rst = 1'b1;
    req_valid = 1'b0; req_kind = 2'b00; req_op = 3'd0; req_pred = 1'b0;
    req_funct4 = 4'd0; req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0;
    req_imm = 32'd0; instr_ready = 1'b1;
    s_req_valid = 1'b0; s_req_kind = 2'b00; s_req_rd = 5'd0;
    repeat (2) @(negedge clk);

    chk("reset req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("reset instr", instr, 32'd0);
    chk("reset addr", {22'd0, instr_addr}, 32'd0);
    chk("reset overflow", {31'd0, overflow}, 32'd0);
    chk("reset halted", {31'd0, halted}, 32'd0);
    rst = 1'b0; s_rst = 1'b0;
    @(negedge clk);
    chk("idle req_ready", {31'd0, req_ready}, 32'd1);

    vecs[0]  = mk("raw_sub", 2'b00, `Rtype, 0, `ALU_SUB, 3, 1, 2, 0, 1,
                  32'h01840402, 0, 0, 0, 0);
    vecs[1]  = mk("li_100", 2'b01, 0, 0, 0, 5, 0, 0, 100, 1,
                  32'h22800064, 0, 0, 0, 0);
    vecs[2]  = mk("li_12345678", 2'b01, 0, 0, 0, 5, 0, 0, 32'h12345678, 5,
                  32'h22800048, 32'h2294080B, 32'h2294428A, 32'h2294080B, 32'h22944278);
    vecs[3]  = mk("nop", 2'b10, 0, 0, 0, 9, 9, 9, 32'hFFFF, 1,
                  32'h20000000, 0, 0, 0, 0);
    vecs[4]  = mk("li_m1", 2'b01, 0, 0, 0, 7, 0, 0, 32'hFFFFFFFF, 1,
                  32'h2383C3FF, 0, 0, 0, 0);
    vecs[5]  = mk("li_m8192", 2'b01, 0, 0, 0, 1, 0, 0, 32'hFFFFE000, 1,
                  32'h20820000, 0, 0, 0, 0);
    vecs[6]  = mk("li_8191", 2'b01, 0, 0, 0, 1, 0, 0, 32'd8191, 1,
                  32'h2081C3FF, 0, 0, 0, 0);
    vecs[7]  = mk("li_8192", 2'b01, 0, 0, 0, 2, 0, 0, 32'd8192, 5,
                  32'h21000000, 32'h2108080B, 32'h21080004, 32'h2108080B, 32'h21080000);
    vecs[8]  = mk("li_m8193", 2'b01, 0, 0, 0, 2, 0, 0, 32'hFFFFDFFF, 5,
                  32'h2103C3FF, 32'h2108080B, 32'h210843FB, 32'h2108080B, 32'h210843FF);
    vecs[9]  = mk("li_rd0", 2'b01, 0, 0, 0, 0, 0, 0, 32'h12345678, 1,
                  32'h20000000, 0, 0, 0, 0);
    vecs[10] = mk("raw_i_pred", 2'b00, `Itype, 1, `ALU_ADD, 4, 6, 0, 32'hFFFF2ABC, 1,
                  32'h321A82BC, 0, 0, 0, 0);
    vecs[11] = mk("raw_m", 2'b00, `Mtype, 0, 4'd3, 1, 2, 9, 32'd5, 1,
                  32'h40880C05, 0, 0, 0, 0);
    vecs[12] = mk("raw_c", 2'b00, `Ctype, 0, 4'hF, 0, 3, 0, 32'd0, 1,
                  32'h600C1C00, 0, 0, 0, 0);
    vecs[13] = mk("raw_f", 2'b00, `Ftype, 0, 4'd5, 2, 3, 31, 32'h3FFF, 1,
                  32'hA10C141F, 0, 0, 0, 0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Executing the LI expansion reproduces the immediate
    begin
      logic [31:0] x;
      x = {{22{vecs[2].w[0][9]}}, vecs[2].w[0][9:0]};
      x = (x << 11) + {18'd0, vecs[2].w[2][17:14], vecs[2].w[2][9:0]};
      x = (x << 11) + {18'd0, vecs[2].w[4][17:14], vecs[2].w[4][9:0]};
      chk("li_12345678 executes", x, 32'h12345678);
    end

    // Backpressure for 3 cycles on word 1 of an expansion, with a competing request
    big = vecs[2];
    send(big);
    chk("bp word0", instr, big.w[0]);
    addr_model++;
    @(negedge clk);
    instr_ready = 1'b0;
    req_valid = 1'b1; req_kind = 2'b10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp stall%0d word", c), instr, big.w[1]);
      chk($sformatf("bp stall%0d addr", c), {22'd0, instr_addr}, 32'(addr_model));
      chk($sformatf("bp stall%0d valid", c), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("bp stall%0d req_ready", c), {31'd0, req_ready}, 32'd0);
      $display("txn bp stall %0d: instr=%h addr=%0d", c, instr, instr_addr);
    end
    req_valid = 1'b0;
    instr_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("bp word[%0d]", i), instr, big.w[i]);
      chk($sformatf("bp addr[%0d]", i), {22'd0, instr_addr}, 32'(addr_model));
      addr_model++;
      @(negedge clk);
    end
    chk("bp idle after", {31'd0, instr_valid}, 32'd0);

    // Reset while step 2 of an expansion is presented
    send(big);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid step2 word", instr, big.w[2]);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_mid addr", {22'd0, instr_addr}, 32'd0);
    rst = 1'b0;
    addr_model = 0;
    repeat (2) @(negedge clk);
    chk("rst_mid no partial", {31'd0, instr_valid}, 32'd0);
    $display("txn rst_mid: valid=%0d addr=%0d", instr_valid, instr_addr);
    run_vec(vecs[0]);

    // Address wrap on the 2-bit instance
    for (int k = 0; k < 5; k++) begin
      s_req_kind = 2'b00; s_req_rd = 5'(k + 1); s_req_valid = 1'b1;
      @(posedge clk);
      #1 s_req_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("wrap word%0d", k), s_instr, 32'(k + 1) << 23);
      chk($sformatf("wrap addr%0d", k), {30'd0, s_instr_addr}, 32'(k % 4));
      chk($sformatf("wrap ovf%0d", k), {31'd0, s_overflow}, (k == 4) ? 32'd1 : 32'd0);
      $display("txn wrap %0d: addr=%0d overflow=%0d", k, s_instr_addr, s_overflow);
      @(negedge clk);
    end
    chk("wrap ovf sticky", {31'd0, s_overflow}, 32'd1);

    // EXIT, then a request that must be refused
    ex = mk("exit", 2'b11, 0, 0, 0, 0, 0, 0, 0, 1, 32'h60001C00, 0, 0, 0, 0);
    send(ex);
    chk("exit word", instr, 32'h60001C00);
    chk("exit addr", {22'd0, instr_addr}, 32'(addr_model));
    chk("exit halted before take", {31'd0, halted}, 32'd0);
    chk("exit req_ready pending", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("exit halted", {31'd0, halted}, 32'd1);
    chk("exit valid after", {31'd0, instr_valid}, 32'd0);
    raw1 = vecs[0];
    req_kind = raw1.kind; req_op = raw1.op; req_rd = raw1.rd; req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("halt%0d req_ready", c), {31'd0, req_ready}, 32'd0);
      chk($sformatf("halt%0d valid", c), {31'd0, instr_valid}, 32'd0);
    end
    $display("txn exit: halted=%0d req_ready=%0d", halted, req_ready);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("halt rst halted", {31'd0, halted}, 32'd0);
    chk("halt rst addr", {22'd0, instr_addr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("halt rst req_ready", {31'd0, req_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
